stage4_memory: RTL and testbench
================================

# stage4_memory

Memory-access stage of the TCORE RV32IMC pipeline, directly downstream of `stage3_execution`. It takes the execution stage's ALU result as the effective address, and its forwarded rs2 value as store data. It runs a request/grant/response handshake with the data-memory port, generates byte strobes, and aligns and sign-extends load data. It stalls the pipeline until the access completes.

## Interface
Parameters:
- `XLEN`, 32: data and address width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `alu_result_i`  in  XLEN  effective address (EX/MEM register copy of the ALU result).
- `write_data_i`  in  XLEN  store data (EX/MEM copy of the forwarded rs2).
- `rd_en_i`  in  1  load request.
- `wr_en_i`  in  1  store request.
- `size_i`  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. The U codes are loads only.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  XLEN  word-aligned address; bits [1:0] are always 0.
- `dmem_wdata_o`  out  XLEN  store data replicated into the target byte lanes.
- `dmem_wstrb_o`  out  4  byte strobes.
- `dmem_gnt_i`  in  1  bus accepted the request this cycle.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  XLEN  read word.
- `ld_data_o`  out  XLEN  aligned, extended load result; meaningful only in the completion cycle.
- `mem_stall_o`  out  1  freeze IF through EX/MEM.
- `misalign_o`  out  1  misaligned access detected (see Configuration).

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- An operation is active when `rd_en_i | wr_en_i`. If both are high, the store wins.
- IDLE, operation active:
  - Drive the request combinationally from the inputs.
  - Latch address, size, byte offset, we and wdata/wstrb every cycle a request is issued from IDLE.
  - If `dmem_gnt_i` and store: operation complete, stay in IDLE.
  - If `dmem_gnt_i` and load: go to WAIT_RVALID.
  - If no grant: go to WAIT_GNT.
- WAIT_GNT: drive the request from the latched registers.
  - On `dmem_gnt_i`: store goes to IDLE (complete); load goes to WAIT_RVALID.
- WAIT_RVALID: `dmem_req_o` = 0.
  - On `dmem_rvalid_i`: go to IDLE, completion cycle.
- `mem_stall_o` = active operation AND NOT completing this cycle. In IDLE with no operation it is 0.
- Store lanes:
  - B: wdata = {4{wd[7:0]}}, wstrb = 0001 << off.
  - H: wdata = {2{wd[15:0]}}, wstrb = 0011 << off.
  - W: wstrb = 1111.
- Load extraction uses the latched offset and size:
  - Select byte `rdata[8*off+:8]` or half `rdata[16*off[1]+:16]`.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Misaligned accesses: H with off[0] = 1, or W with off ≠ 0.
- Undefined `size_i` codes are treated as W.

## Timing
- Reset values: state IDLE, `dmem_req_o` 0, `dmem_we_o` 0, `dmem_addr_o` 0, `dmem_wdata_o` 0, `dmem_wstrb_o` 0, `ld_data_o` 0, `mem_stall_o` 0, `misalign_o` 0.
- Reset mid-operation returns the FSM to IDLE asynchronously. `dmem_req_o` falls immediately, and any outstanding response is ignored.
- Store latency: 0 extra cycles with a same-cycle grant; otherwise one extra cycle per grant-wait cycle.
- Load latency: at least 1 cycle after grant. `ld_data_o` is valid in the `dmem_rvalid_i` cycle, with `mem_stall_o` = 0 so MEM/WB captures it on that edge.
- `dmem_rvalid_i` is never asserted in the same cycle as the matching `dmem_gnt_i`. The block ignores `dmem_rvalid_i` outside WAIT_RVALID.
- While in WAIT_GNT, the request fields are held stable from the latches regardless of the inputs.
- Back-to-back accesses: the next operation may issue from IDLE in the cycle after completion.

## Configuration
- `TCORE_MISALIGN_TRAP_EN` defined:
  - A misaligned access asserts `misalign_o` combinationally in the cycle it is presented in IDLE.
  - No bus request is issued, the FSM stays in IDLE, and `mem_stall_o` = 0. The trap logic flushes.
- Not defined:
  - `misalign_o` is tied to 0.
  - The access proceeds with the offset truncated to the size alignment: H uses off & 2, W uses 0.

## Test plan
- Store word: addr 0x1000_0008, data 0xDEADBEEF, gnt same cycle → req=1, wstrb=1111, stall=0, FSM stays in IDLE.
- Store byte: addr 0x1003, data 0x000000A5, gnt delayed 2 cycles → wdata 0xA5A5A5A5, wstrb 1000, stall high for exactly 2 cycles, request fields stable throughout.
- Load byte signed: addr 0x2001, rdata 0x0000_8000 arriving 1 cycle after gnt → ld_data 0xFFFF_FF80, stall=0 in the rvalid cycle. Repeat with BU → 0x0000_0080.
- Load half unsigned: addr 0x2002, rdata 0xBEEF_1234, gnt stalled 3 cycles, rvalid 2 cycles later → ld_data 0x0000_BEEF, stall high for 5 cycles total.
- Misaligned LW at 0x2001 with `TCORE_MISALIGN_TRAP_EN` → misalign_o=1, req=0, stall=0. Without the macro → access issued at 0x2000, misalign_o=0.
- Reset asserted while in WAIT_RVALID → req/stall drop immediately. A later rvalid is ignored, and the next load completes normally.

Source files
------------

// File: rtl/stage4_memory.sv
// TCORE memory-access stage: data-memory request/grant/response handshake, store lane
// steering and load alignment. Optional macro TCORE_MISALIGN_TRAP_EN traps misaligned accesses.
module stage4_memory #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic            rd_en_i,
    input  logic            wr_en_i,
    input  logic [2:0]      size_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] ld_data_o,
    output logic            mem_stall_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Undefined funct3 codes fall through to word.
    function automatic logic [1:0] decode_kind(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: decode_kind = SZ_B;
            3'b001, 3'b101: decode_kind = SZ_H;
            default:        decode_kind = SZ_W;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] kind, input logic [1:0] off);
        case (kind)
            SZ_B:    align_offset = off;
            SZ_H:    align_offset = {off[1], 1'b0};
            default: align_offset = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] kind, input logic [1:0] off);
        case (kind)
            SZ_B:    store_strobe = 4'b0001 << off;
            SZ_H:    store_strobe = 4'b0011 << off;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] kind, input logic [XLEN-1:0] wd);
        case (kind)
            SZ_B:    store_data = {(XLEN/8){wd[7:0]}};
            SZ_H:    store_data = {(XLEN/16){wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [1:0]      kind,
                                                     input logic            uns,
                                                     input logic [1:0]      off);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (kind)
            SZ_B:    load_extract = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            SZ_H:    load_extract = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        kind_q, kind_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;

    logic              op_active_s;
    logic [1:0]        in_kind_s;
    logic [1:0]        in_off_s;
    logic [XLEN-1:0]   in_addr_s;
    logic              trap_s;

    logic              req_s;
    logic              we_s;
    logic [XLEN-1:0]   addr_s;
    logic [XLEN-1:0]   wdata_s;
    logic [3:0]        wstrb_s;
    logic [XLEN-1:0]   ld_s;
    logic              stall_s;
    logic              misalign_s;

    assign op_active_s = rd_en_i | wr_en_i;
    assign in_kind_s   = decode_kind(size_i);
    assign in_off_s    = align_offset(in_kind_s, alu_result_i[1:0]);
    assign in_addr_s   = {alu_result_i[XLEN-1:2], 2'b00};

`ifdef TCORE_MISALIGN_TRAP_EN
    logic misalign_in_s;
    assign misalign_in_s = ((in_kind_s == SZ_H) && alu_result_i[0]) ||
                           ((in_kind_s == SZ_W) && (alu_result_i[1:0] != 2'b00));
    assign trap_s = op_active_s && misalign_in_s;
`else
    assign trap_s = 1'b0;
`endif

    // Next-state, request latching and combinational bus/pipeline outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        kind_d     = kind_q;
        uns_d      = uns_q;
        off_d      = off_q;
        req_s      = 1'b0;
        we_s       = 1'b0;
        addr_s     = '0;
        wdata_s    = '0;
        wstrb_s    = 4'b0000;
        ld_s       = '0;
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_s) begin
                    misalign_s = 1'b1;
                end else if (op_active_s) begin
                    req_s   = 1'b1;
                    we_s    = wr_en_i;
                    addr_s  = in_addr_s;
                    wdata_s = wr_en_i ? store_data(in_kind_s, write_data_i) : '0;
                    wstrb_s = wr_en_i ? store_strobe(in_kind_s, in_off_s) : 4'b0000;
                    addr_d  = addr_s;
                    we_d    = we_s;
                    wdata_d = wdata_s;
                    wstrb_d = wstrb_s;
                    kind_d  = in_kind_s;
                    uns_d   = size_i[2];
                    off_d   = in_off_s;
                    if (!dmem_gnt_i) begin
                        state_d = WAIT_GNT;
                        stall_s = 1'b1;
                    end else if (wr_en_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RVALID;
                        stall_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_GNT: begin
                req_s   = 1'b1;
                we_s    = we_q;
                addr_s  = addr_q;
                wdata_s = wdata_q;
                wstrb_s = wstrb_q;
                if (!dmem_gnt_i) begin
                    stall_s = 1'b1;
                end else if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RVALID;
                    stall_s = 1'b1;
                end
            end
            WAIT_RVALID: begin
                addr_s = addr_q;
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    ld_s    = load_extract(dmem_rdata_i, kind_q, uns_q, off_q);
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request-field registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            kind_q  <= SZ_W;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            kind_q  <= kind_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    // Outputs are forced quiet while reset is held, even if the pipeline presents an access.
    assign dmem_req_o   = rst_i ? 1'b0    : req_s;
    assign dmem_we_o    = rst_i ? 1'b0    : we_s;
    assign dmem_addr_o  = rst_i ? '0      : addr_s;
    assign dmem_wdata_o = rst_i ? '0      : wdata_s;
    assign dmem_wstrb_o = rst_i ? 4'b0000 : wstrb_s;
    assign ld_data_o    = rst_i ? '0      : ld_s;
    assign mem_stall_o  = rst_i ? 1'b0    : stall_s;
    assign misalign_o   = rst_i ? 1'b0    : misalign_s;

endmodule

// File: tb/tb_stage4_memory.sv
// Scoreboard bench for stage4_memory: stimulus queues expected bus requests and load
// responses, a negedge monitor compares them whenever the DUT presents them.
module tb_stage4_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  size = 3'b010;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [31:0] ld_data;
    logic        mem_stall, misalign;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        chk_ld;
        logic [31:0] ld;
        logic        stall;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    stage4_memory #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .alu_result_i (alu_result),
        .write_data_i (write_data),
        .rd_en_i      (rd_en),
        .wr_en_i      (wr_en),
        .size_i       (size),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_wstrb_o (dmem_wstrb),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata),
        .ld_data_o    (ld_data),
        .mem_stall_o  (mem_stall),
        .misalign_o   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every presented request must match the queue head (stable until granted).
    always @(negedge clk) begin
        if (dmem_req) begin
            check("req expected", 32'(req_q.size() != 0), 32'd1);
            check("misalign low on req", 32'(misalign), 32'd0);
            if (req_q.size() != 0) begin
                check("req addr", dmem_addr, req_q[0].addr);
                check("req we", 32'(dmem_we), 32'(req_q[0].we));
                if (req_q[0].we) begin
                    check("req wdata", dmem_wdata, req_q[0].wdata);
                    check("req wstrb", 32'(dmem_wstrb), 32'(req_q[0].wstrb));
                end
                if (dmem_gnt) void'(req_q.pop_front());
            end
        end
        if (dmem_rvalid) begin
            check("resp expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
                if (resp_q[0].chk_ld) check("ld_data", ld_data, resp_q[0].ld);
                check("stall at rvalid", 32'(mem_stall), 32'(resp_q[0].stall));
                void'(resp_q.pop_front());
            end
        end
    end

    // One access: grant after gnt_dly wait cycles, load data rv_dly cycles after grant.
    task automatic run_op(input string name, input logic is_st, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] sz,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input req_t exp_req, input logic [31:0] exp_ld, input int exp_stalls);
        int stalls;
        stalls = 0;
        @(posedge clk); #1;
        alu_result = addr; write_data = wd; size = sz;
        wr_en = is_st; rd_en = !is_st;
        dmem_gnt = (gnt_dly == 0); dmem_rvalid = 1'b0;
        req_q.push_back(exp_req);
        for (int c = 0; c < gnt_dly; c++) begin
            @(negedge clk); if (mem_stall) stalls++;
            @(posedge clk); #1;
            alu_result = ~addr; write_data = ~wd; size = sz ^ 3'b001;
            dmem_gnt = (c == gnt_dly - 1);
        end
        @(negedge clk); if (mem_stall) stalls++;
        if (!is_st) begin
            for (int c = 0; c < rv_dly; c++) begin
                @(posedge clk); #1;
                dmem_gnt = 1'b0; rd_en = 1'b0;
                dmem_rvalid = (c == rv_dly - 1);
                if (c == rv_dly - 1) begin
                    dmem_rdata = rdata;
                    resp_q.push_back('{1'b1, exp_ld, 1'b0});
                end
                @(negedge clk); if (mem_stall) stalls++;
            end
        end
        check({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check("rst req", 32'(dmem_req), 32'd0);
        check("rst we", 32'(dmem_we), 32'd0);
        check("rst addr", dmem_addr, 32'h0);
        check("rst wdata", dmem_wdata, 32'h0);
        check("rst wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst ld_data", ld_data, 32'h0);
        check("rst stall", 32'(mem_stall), 32'd0);
        check("rst misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        run_op("SW", 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 3'b010, 0, 0, 32'h0,
               '{32'h1000_0008, 1'b1, 32'hDEAD_BEEF, 4'b1111}, 32'h0, 0);
        run_op("SB", 1'b1, 32'h0000_1003, 32'h0000_00A5, 3'b000, 2, 0, 32'h0,
               '{32'h0000_1000, 1'b1, 32'hA5A5_A5A5, 4'b1000}, 32'h0, 2);
        run_op("SH", 1'b1, 32'h0000_3002, 32'h0000_CAFE, 3'b001, 1, 0, 32'h0,
               '{32'h0000_3000, 1'b1, 32'hCAFE_CAFE, 4'b1100}, 32'h0, 1);
        run_op("LB", 1'b0, 32'h0000_2001, 32'h0, 3'b000, 0, 1, 32'h0000_8000,
               '{32'h0000_2000, 1'b0, 32'h0, 4'b0000}, 32'hFFFF_FF80, 1);
        run_op("LBU", 1'b0, 32'h0000_2001, 32'h0, 3'b100, 0, 1, 32'h0000_8000,
               '{32'h0000_2000, 1'b0, 32'h0, 4'b0000}, 32'h0000_0080, 1);
        run_op("LHU", 1'b0, 32'h0000_2002, 32'h0, 3'b101, 3, 2, 32'hBEEF_1234,
               '{32'h0000_2000, 1'b0, 32'h0, 4'b0000}, 32'h0000_BEEF, 5);
        run_op("LH", 1'b0, 32'h0000_2000, 32'h0, 3'b001, 0, 1, 32'h1234_8001,
               '{32'h0000_2000, 1'b0, 32'h0, 4'b0000}, 32'hFFFF_8001, 1);
        run_op("LW", 1'b0, 32'h0000_2004, 32'h0, 3'b010, 1, 3, 32'hCAFE_F00D,
               '{32'h0000_2004, 1'b0, 32'h0, 4'b0000}, 32'hCAFE_F00D, 4);
        go_idle();
        @(negedge clk);
        check("idle req", 32'(dmem_req), 32'd0);
        check("idle stall", 32'(mem_stall), 32'd0);

`ifdef TCORE_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        alu_result = 32'h0000_2001; size = 3'b010; rd_en = 1'b1; dmem_gnt = 1'b1;
        @(negedge clk);
        check("trap misalign", 32'(misalign), 32'd1);
        check("trap req", 32'(dmem_req), 32'd0);
        check("trap stall", 32'(mem_stall), 32'd0);
        go_idle();
`else
        run_op("LW misaligned", 1'b0, 32'h0000_2001, 32'h0, 3'b010, 0, 1, 32'h1122_3344,
               '{32'h0000_2000, 1'b0, 32'h0, 4'b0000}, 32'h1122_3344, 1);
        go_idle();
`endif

        // Reset while waiting for read data.
        @(posedge clk); #1;
        alu_result = 32'h0000_2008; size = 3'b010; rd_en = 1'b1; wr_en = 1'b0; dmem_gnt = 1'b1;
        req_q.push_back('{32'h0000_2008, 1'b0, 32'h0, 4'b0000});
        @(negedge clk);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("stall in WAIT_RVALID", 32'(mem_stall), 32'd1);
        #3;
        rst = 1'b1; rd_en = 1'b1; alu_result = 32'h0000_2010;
        #1;
        check("async rst req", 32'(dmem_req), 32'd0);
        check("async rst stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_0000;
        resp_q.push_back('{1'b0, 32'h0, 1'b0});
        @(negedge clk);
        check("stray rvalid req", 32'(dmem_req), 32'd0);
        run_op("LW after rst", 1'b0, 32'h0000_200C, 32'h0, 3'b010, 0, 1, 32'h55AA_55AA,
               '{32'h0000_200C, 1'b0, 32'h0, 4'b0000}, 32'h55AA_55AA, 1);
        go_idle();
        @(negedge clk);
        check("req queue drained", 32'(req_q.size()), 32'd0);
        check("resp queue drained", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
